// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its branch predictor.
// The predictor itself is only built when FETCH_BPRED_EN is defined.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        CTR_SNT = 2'd0,
        CTR_WNT = 2'd1,
        CTR_WT  = 2'd2,
        CTR_ST  = 2'd3
    } ctr_e;

    // tag holds pc[31:2] shifted right by the index width, zero-extended
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        ctr_e        ctr;
        logic [29:0] target;
    } bht_entry_t;

    function automatic ctr_e ctr_update(input ctr_e ctr, input logic taken);
        ctr_e res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                res = ctr_e'(ctr + 2'd1);
            end
        end else begin
            if (ctr != CTR_SNT) begin
                res = ctr_e'(ctr - 2'd1);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: combinational lookup, one update per cycle.
// Instantiated by stage_fetch only when FETCH_BPRED_EN is defined.
module branch_predictor
    import fetch_pkg::*;
#(
    parameter int BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] lookup_pc_i,
    output logic        lookup_taken_o,
    output logic [29:0] lookup_target_o,
    input  logic        update_i,
    input  logic [29:0] update_pc_i,
    input  logic        update_taken_i,
    input  logic [29:0] update_target_i
);

    localparam int IDX = $clog2(BHT_ENTRIES);

    bht_entry_t       entries_q [BHT_ENTRIES];
    logic [IDX-1:0]   lk_idx;
    logic [IDX-1:0]   up_idx;
    logic [29:0]      lk_tag;
    logic [29:0]      up_tag;
    bht_entry_t       lk_e;
    bht_entry_t       up_e;
    bht_entry_t       up_d;
    logic             up_hit;

    assign lk_idx = lookup_pc_i[IDX-1:0];
    assign up_idx = update_pc_i[IDX-1:0];
    assign lk_tag = lookup_pc_i >> IDX;
    assign up_tag = update_pc_i >> IDX;

    always_comb begin
        lk_e            = entries_q[lk_idx];
        lookup_taken_o  = lk_e.valid && (lk_e.tag == lk_tag) && (lk_e.ctr >= CTR_WT);
        lookup_target_o = lk_e.target;

        up_e   = entries_q[up_idx];
        up_hit = up_e.valid && (up_e.tag == up_tag);
        up_d   = up_e;
        if (up_hit) begin
            up_d.ctr = ctr_update(up_e.ctr, update_taken_i);
            if (update_taken_i) begin
                up_d.target = update_target_i;
            end
        end else begin
            up_d.valid  = 1'b1;
            up_d.tag    = up_tag;
            up_d.ctr    = update_taken_i ? CTR_WT : CTR_WNT;
            up_d.target = update_target_i;
        end
    end

    // Lookup reads the old entry; a same-index update only lands at the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                entries_q[i] <= '{valid: 1'b0, tag: '0, ctr: CTR_WNT, target: '0};
            end
        end else if (update_i) begin
            entries_q[up_idx] <= up_d;
        end
    end

endmodule

// File: rtl/stage_fetch.sv
// Instruction fetch stage: fetch PC register, next-PC select, synchronous imem address.
// Define FETCH_BPRED_EN to build in the direct-mapped branch predictor.
module stage_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirectPc,
    input  logic        bUpdate,
    input  logic [31:0] bUpdatePc,
    input  logic        bUpdateTaken,
    input  logic [31:0] bUpdateTarget,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemRdata,
    output logic [31:0] instrF,
    output logic [31:0] pcF,
    output logic [31:0] pcPlus4F,
    output logic        bPredictedTakenF
);

    logic [29:0] pc_q;
    logic [29:0] pc_d;
    logic [29:0] pc_plus1;
    logic        pred_taken;
    logic [29:0] pred_target;

    assign pc_plus1 = pc_q + 30'd1;

`ifdef FETCH_BPRED_EN
    logic        lk_taken;
    logic [29:0] lk_target;
    logic        hold_q;
    logic        held_taken_q;
    logic [29:0] held_target_q;
    logic        unused_ok;

    branch_predictor #(
        .BHT_ENTRIES(BHT_ENTRIES)
    ) u_bpred (
        .clk            (clk),
        .rst            (rst),
        .lookup_pc_i    (pc_q),
        .lookup_taken_o (lk_taken),
        .lookup_target_o(lk_target),
        .update_i       (bUpdate),
        .update_pc_i    (bUpdatePc[31:2]),
        .update_taken_i (bUpdateTaken),
        .update_target_i(bUpdateTarget[31:2])
    );

    // While a fetch is held, freeze the prediction it was first shown with so
    // an update to its own entry cannot change it mid-stall.
    assign pred_taken  = hold_q ? held_taken_q : lk_taken;
    assign pred_target = hold_q ? held_target_q : lk_target;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q        <= 1'b0;
            held_taken_q  <= 1'b0;
            held_target_q <= '0;
        end else begin
            hold_q        <= stall && !flush;
            held_taken_q  <= pred_taken;
            held_target_q <= pred_target;
        end
    end

    assign unused_ok = ^{bUpdatePc[1:0], bUpdateTarget[1:0], redirectPc[1:0]};
`else
    logic unused_ok;

    assign pred_taken  = 1'b0;
    assign pred_target = '0;
    assign unused_ok   = ^{bUpdate, bUpdatePc, bUpdateTaken, bUpdateTarget, redirectPc[1:0]};
`endif

    always_comb begin
        if (flush) begin
            pc_d = redirectPc[31:2];
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end else begin
            pc_d = pc_plus1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= RESET_PC[31:2];
        end else begin
            pc_q <= pc_d;
        end
    end

    // imemAddr is the next PC so the 1-cycle memory lines up with pcF.
    assign imemAddr         = rst ? {pc_d, 2'b00} : {RESET_PC[31:2], 2'b00};
    assign instrF           = imemRdata;
    assign pcF              = {pc_q, 2'b00};
    assign pcPlus4F         = {pc_plus1, 2'b00};
    assign bPredictedTakenF = rst && !flush && pred_taken;

endmodule
